// File: rtl/sram_ctrl_if.sv
// CPU-side request/response bundle for sram_ctrl.
// The master drives a request (req/wr/addr/wdata); the slave returns
// ready, the read word and its valid strobe.
interface sram_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) ();
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output req, wr, addr, wdata,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  req, wr, addr, wdata,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/sram_ctrl.sv
// Sequenced controller for an external asynchronous SRAM.
// Each access runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES+1 cycles) -> HOLD -> IDLE.
// Every SRAM pin and every handshake output comes straight from a flop.
// Optional macro SRAM_CTRL_STAT_EN adds rd_count/wr_count access counters.
module sram_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
`ifdef SRAM_CTRL_STAT_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    // 4 bits covers the full 0..15 wait-state range.
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              is_wr_q,  is_wr_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              drive_q,  drive_d;
    logic              ce_n_q,   ce_n_d;
    logic              oe_n_q,   oe_n_d;
    logic              we_n_q,   we_n_d;
    logic              ready_q,  ready_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              rvalid_q, rvalid_d;
`ifdef SRAM_CTRL_STAT_EN
    logic [31:0]       rd_cnt_q, rd_cnt_d;
    logic [31:0]       wr_cnt_q, wr_cnt_d;
`endif

    // Next-state and next-output computation; outputs are decided one cycle
    // ahead so that the pins change only on the registered edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        drive_d  = drive_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        ready_d  = ready_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
`ifdef SRAM_CTRL_STAT_EN
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d = S_SETUP;
                    is_wr_d = bus.wr;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    ce_n_d  = 1'b0;
                    // Reads open the output buffer immediately; writes drive
                    // the bus instead, so the two never overlap.
                    oe_n_d  = bus.wr;
                    drive_d = bus.wr;
                    we_n_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = WAIT_LOAD;
                we_n_d  = ~is_wr_q;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    we_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    if (!is_wr_q) begin
                        rdata_d  = sram_data;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                // Address and write data stay put through HOLD for data hold
                // after the WE rising edge; release everything on exit.
                state_d = S_IDLE;
                ce_n_d  = 1'b1;
                drive_d = 1'b0;
                ready_d = 1'b1;
`ifdef SRAM_CTRL_STAT_EN
                if (is_wr_q) wr_cnt_d = wr_cnt_q + 32'd1;
                else         rd_cnt_d = rd_cnt_q + 32'd1;
`endif
            end
            default: begin
                state_d = S_IDLE;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                drive_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output register; reset forces every pin inactive at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            drive_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ready_q  <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef SRAM_CTRL_STAT_EN
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            drive_q  <= drive_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef SRAM_CTRL_STAT_EN
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
`endif
        end
    end

    assign sram_data  = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign sram_addr  = addr_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign bus.ready  = ready_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
`ifdef SRAM_CTRL_STAT_EN
    assign rd_count   = rd_cnt_q;
    assign wr_count   = wr_cnt_q;
`endif

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Parametrised, fully registered controller for an external asynchronous SRAM, such as the board's RAM1/RAM2 chips.
- Sits between the CPU memory stage and the SRAM pins. It replaces direct, clock-gated OE/WE driving with a sequenced access: SETUP, ACCESS with programmable wait states, then HOLD.
- Provides a req/ready handshake and a registered read-data-valid strobe.
- Every SRAM control pin comes from a flop. There are no combinational clock paths to the pins.

Parameters:
- ADDR_W, 18, width of word address and SRAM address bus.
- DATA_W, 16, width of data word and SRAM data bus.
- WAIT_CYCLES, 1, extra ACCESS cycles beyond the first; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  1  access request; sampled only while ready=1.
- wr  input  1  1=write, 0=read; sampled with req.
- addr  input  ADDR_W  word address; sampled with req.
- wdata  input  DATA_W  write data; sampled with req.
- ready  output  1  1 exactly when the controller is in IDLE.
- rdata  output  DATA_W  last read word; held until the next read completes.
- rvalid  output  1  one-cycle pulse when rdata is updated.
- sram_addr  output  ADDR_W  SRAM address pins.
- sram_data  inout  DATA_W  SRAM data pins.
- sram_ce_n  output  1  chip enable, active low.
- sram_oe_n  output  1  output enable, active low.
- sram_we_n  output  1  write enable, active low.

Behaviour:
- Reset values, applied asynchronously on rst=1:
  - state IDLE, so ready=1.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
  - sram_data tri-stated (Z).
  - sram_addr=0, rdata=0, rvalid=0.
  - wait counter=0.
- Handshake:
  - A transfer is accepted on the rising edge where req=1 and ready=1.
  - addr, wdata and wr are latched at that edge.
  - req while ready=0 is ignored, not queued; the requester must hold req until it sees ready.
- States:
  - IDLE: strobes inactive, bus Z. On acceptance go to SETUP.
  - SETUP (1 cycle): sram_addr=latched addr, sram_ce_n=0.
    - Read: sram_oe_n=0, bus Z.
    - Write: sram_oe_n=1, bus driven with wdata, sram_we_n=1.
    - Next state: ACCESS; counter loaded with WAIT_CYCLES.
  - ACCESS (WAIT_CYCLES+1 cycles): outputs as in SETUP, except that a write also drives sram_we_n=0.
    - The counter decrements each cycle; leave to HOLD when the counter is 0.
    - Read: rdata captures sram_data at the edge leaving ACCESS.
  - HOLD (1 cycle): sram_we_n=1, sram_oe_n=1, sram_ce_n=0.
    - Address and write data are still driven, giving data hold after the WE rising edge.
    - rvalid=1 in this cycle for reads only.
    - Next state: IDLE.
- Latency:
  - Accept edge to ready=1 is WAIT_CYCLES+4 cycles (5 at default).
  - rvalid is asserted WAIT_CYCLES+3 cycles after the accept edge.
  - Throughput is one access per WAIT_CYCLES+4 cycles.
- Bus contention rules:
  - sram_data is driven only in SETUP/ACCESS/HOLD of a write, and never while sram_oe_n=0.
  - The mandatory IDLE cycle between accesses gives read/write turnaround.
- Reset mid-operation: the access is aborted immediately and all pins go inactive asynchronously. A write in flight leaves undefined contents at that address. rdata is zeroed.
- sram_addr holds its last value in IDLE; it is not cleared.

Optional Feature:
- Macro: SRAM_CTRL_STAT_EN.
- Defined:
  - Adds output ports rd_count[31:0] and wr_count[31:0], reset to 0.
  - Each increments by 1 in the HOLD cycle of a read or a write respectively.
  - Each wraps modulo 2^32.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset check: rst pulse asynchronously, mid-cycle -> ce_n/oe_n/we_n=1, sram_data=Z, ready=1, rdata=0, rvalid=0, without waiting for a clock edge.
- Write, default params: req=1, wr=1, addr=0x00123, wdata=0xBEEF accepted at edge 0 ->
  - cycles 1-4: sram_addr=0x00123, sram_data=0xBEEF.
  - we_n=0 only in cycles 2-3.
  - ready=1 from cycle 5.
  - The SRAM model holds 0xBEEF.
- Read-back: read of 0x00123 accepted at edge 0 ->
  - oe_n=0 in cycles 1-3, bus Z throughout.
  - rvalid=1 only in cycle 4 with rdata=0xBEEF.
  - rdata holds 0xBEEF afterwards.
- Ignored request: pulse req with addr=0x3FFFF while ready=0 -> no second access occurs; the in-flight access completes unchanged.
- WAIT_CYCLES=0 and WAIT_CYCLES=15 with back-to-back write->read to addr 0x3FFFF, data 0x5A5A ->
  - ACCESS length is 1 and 16 cycles respectively.
  - Correct data is read back.
  - The bus is never driven while oe_n=0 (contention assertion).
- Reset mid-ACCESS of a write, then SRAM_CTRL_STAT_EN build ->
  - The reset aborts the write, pins go inactive, ready=1.
  - With the macro: 3 reads + 2 writes give rd_count=3, wr_count=2; rst clears both counts to 0.
